scratch_pad_dumper: RTL and testbench

Readback engine for a `ScratchPadMem` bank. It walks a word range through the bank's synchronous read port and streams each word out as bytes on a valid/ready byte channel, least-significant byte first. Byte order matches the bank's byte lanes: lane 0 is bits 7:0. It is the runtime counterpart of the hex-file bank initialisation: it dumps bank contents for a debug UART or test host instead of loading them.

---
 rtl/scratch_pad_dumper.sv | 150 +++++++++++++++
 tb/tb_scratch_pad_dumper.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_pad_dumper.sv
// Streams a word range of a ScratchPadMem bank out as bytes, LSB first, over a valid/ready channel.
// Define SCRATCH_PAD_DUMPER_CHECKSUM_EN to append an 8-bit running-sum byte after the last data byte.
module scratch_pad_dumper #(
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  input  logic [31:0]        io_baseAddress,
  input  logic [COUNT_W-1:0] io_wordCount,
  output logic [31:0]        io_rdAddress,
  input  logic [31:0]        io_rdData,
  output logic               io_txValid,
  input  logic               io_txReady,
  output logic [7:0]         io_txData,
  output logic               io_busy,
  output logic               io_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
    CSUM  = 3'd4,
`endif
    DONE  = 3'd5
  } stateType;

  stateType           stateReg, stateNext;
  logic [31:0]        addrReg, addrNext;
  logic [COUNT_W-1:0] remainingReg, remainingNext;
  logic [31:0]        bufferReg, bufferNext;
  logic [1:0]         idxReg, idxNext;
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
  logic [7:0]         checksumReg, checksumNext;
`endif

  logic [7:0] laneBytes [4];
  logic       handshake;

  // Lane gi of the buffer is bank byte lane gi (lane 0 = bits 7:0).
  for (genvar gi = 0; gi < 4; gi++) begin : gLane
    assign laneBytes[gi] = bufferReg[8*gi +: 8];
  end

  assign handshake    = io_txValid & io_txReady;
  assign io_rdAddress = addrReg;
  assign io_busy      = (stateReg != IDLE);
  assign io_done      = (stateReg == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg     <= IDLE;
      addrReg      <= '0;
      remainingReg <= '0;
      bufferReg    <= '0;
      idxReg       <= '0;
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
      checksumReg  <= '0;
`endif
    end else begin
      stateReg     <= stateNext;
      addrReg      <= addrNext;
      remainingReg <= remainingNext;
      bufferReg    <= bufferNext;
      idxReg       <= idxNext;
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
      checksumReg  <= checksumNext;
`endif
    end
  end

  always_comb begin
    stateNext     = stateReg;
    addrNext      = addrReg;
    remainingNext = remainingReg;
    bufferNext    = bufferReg;
    idxNext       = idxReg;
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
    checksumNext  = checksumReg;
`endif
    io_txValid    = 1'b0;
    io_txData     = 8'h00;

    case (stateReg)
      IDLE: begin
        if (io_start) begin
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
          checksumNext = 8'h00;
`endif
          if (io_wordCount != '0) begin
            addrNext      = io_baseAddress & ~32'h3;
            remainingNext = io_wordCount;
            stateNext     = FETCH;
          end else begin
            stateNext = DONE;
          end
        end
      end

      FETCH: stateNext = LOAD;

      LOAD: begin
        bufferNext = io_rdData;
        idxNext    = 2'd0;
        stateNext  = SEND;
      end

      SEND: begin
        io_txValid = 1'b1;
        io_txData  = laneBytes[idxReg];
        if (handshake) begin
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
          checksumNext = checksumReg + laneBytes[idxReg];
`endif
          idxNext = idxReg + 2'd1;
          if (idxReg == 2'd3) begin
            if (remainingReg == COUNT_W'(1)) begin
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
              stateNext = CSUM;
`else
              stateNext = DONE;
`endif
            end else begin
              // 32-bit add wraps 0xFFFFFFFC back to 0 on its own.
              addrNext      = addrReg + 32'd4;
              remainingNext = remainingReg - COUNT_W'(1);
              stateNext     = FETCH;
            end
          end
        end
      end

`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
      CSUM: begin
        io_txValid = 1'b1;
        io_txData  = checksumReg;
        if (handshake) stateNext = DONE;
      end
`endif

      DONE: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scratch_pad_dumper.sv
// Scoreboarded bench for scratch_pad_dumper: a bank model feeds reads, a monitor checks every accepted byte.
module tb_scratch_pad_dumper;
  localparam int COUNT_W = 16;
`ifdef SCRATCH_PAD_DUMPER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               io_start = 1'b0;
  logic [31:0]        io_baseAddress = '0;
  logic [COUNT_W-1:0] io_wordCount = '0;
  logic [31:0]        io_rdAddress;
  logic [31:0]        io_rdData = '0;
  logic               io_txValid;
  logic               io_txReady = 1'b1;
  logic [7:0]         io_txData;
  logic               io_busy;
  logic               io_done;

  int checks = 0;
  int failures = 0;
  int doneCount = 0;
  logic [7:0] expQ [$];
  logic [31:0] mem [logic [31:0]];
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic [7:0] prevData = 8'h00;

  scratch_pad_dumper #(.COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .io_start(io_start),
    .io_baseAddress(io_baseAddress), .io_wordCount(io_wordCount),
    .io_rdAddress(io_rdAddress), .io_rdData(io_rdData),
    .io_txValid(io_txValid), .io_txReady(io_txReady), .io_txData(io_txData),
    .io_busy(io_busy), .io_done(io_done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memRead(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Bank model: synchronous read, data valid the cycle after the address.
  always @(posedge clock) io_rdData <= memRead(io_rdAddress);

  // Monitor: hold-stability under backpressure and scoreboard pop on each handshake.
  always @(negedge clock) begin
    if (reset) begin
      if (io_done) doneCount <= doneCount + 1;
      if (prevValid && !prevReady) begin
        checks++;
        if (io_txValid !== 1'b1 || io_txData !== prevData) begin
          failures++;
          $display("FAIL hold: valid=%b data=%02h required valid=1 data=%02h", io_txValid, io_txData, prevData);
        end
      end
      if (io_txValid && io_txReady) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL extra_byte: got %02h with nothing expected", io_txData);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          if (io_txData !== e) begin
            failures++;
            $display("FAIL byte: got %02h required %02h", io_txData, e);
          end else begin
            $display("byte %02h ok", io_txData);
          end
        end
      end
      prevValid <= io_txValid;
      prevReady <= io_txReady;
      prevData  <= io_txData;
    end else begin
      prevValid <= 1'b0;
    end
  end

  task automatic pushExpected(input logic [31:0] base, input int count);
    logic [31:0] a;
    logic [31:0] w;
    logic [7:0] sum;
    a = base & ~32'h3;
    sum = 8'h00;
    for (int i = 0; i < count; i++) begin
      w = memRead(a);
      for (int b = 0; b < 4; b++) begin
        expQ.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
      a = a + 32'd4;
    end
    if (CS == 1 && count != 0) expQ.push_back(sum);
  endtask

  // Called at posedge+1 in IDLE; the next posedge is edge 0.
  task automatic startDump(input logic [31:0] base, input int count);
    io_baseAddress = base;
    io_wordCount = COUNT_W'(count);
    io_start = 1'b1;
    pushExpected(base, count);
    @(posedge clock); #1;
    io_start = 1'b0;
  endtask

  task automatic runUntilDone(input int budget, output int doneCycle, output int firstValid);
    doneCycle = -1;
    firstValid = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (io_txValid && firstValid < 0) firstValid = k;
      if (io_done) begin
        doneCycle = k;
        break;
      end
      @(posedge clock); #1;
    end
    if (doneCycle < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: no io_done within %0d cycles", budget);
    end else begin
      @(posedge clock); #1;
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end else $display("%s ok (%0d)", name, got);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (io_rdAddress !== 32'h0 || io_txValid !== 1'b0 || io_txData !== 8'h00 ||
        io_busy !== 1'b0 || io_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: addr=%08h valid=%b data=%02h busy=%b done=%b required all 0",
               io_rdAddress, io_txValid, io_txData, io_busy, io_done);
    end else $display("reset_outputs ok");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_word();
    int d, f;
    mem[32'h100] = 32'h11223344;
    io_txReady = 1'b1;
    startDump(32'h100, 1);
    runUntilDone(50, d, f);
    if (d >= 0) begin
      checkInt("single_first_valid", f, 3);
      checkInt("single_done_cycle", d, 7 + CS);
    end
    checkInt("single_queue_empty", expQ.size(), 0);
    checks++;
    if (io_rdAddress !== 32'h100) begin
      failures++;
      $display("FAIL idle_addr_hold: got %08h required 00000100", io_rdAddress);
    end else $display("idle_addr_hold ok");
  endtask

  task automatic test_two_words();
    int d, f;
    mem[32'h200] = 32'h11223344;
    mem[32'h204] = 32'h55667788;
    startDump(32'h200, 2);
    runUntilDone(80, d, f);
    if (d >= 0) checkInt("two_done_cycle", d, 13 + CS);
    checkInt("two_queue_empty", expQ.size(), 0);
  endtask

  task automatic test_backpressure();
    int d;
    d = -1;
    startDump(32'h100, 1);
    for (int k = 1; k <= 40; k++) begin
      io_txReady = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
      @(negedge clock);
      if (k >= 4 && k <= 8) begin
        checks++;
        if (io_txValid !== 1'b1 || io_txData !== 8'h33) begin
          failures++;
          $display("FAIL bp_hold c%0d: valid=%b data=%02h required 1/33", k, io_txValid, io_txData);
        end
      end
      if (io_done) begin
        d = k;
        break;
      end
      @(posedge clock); #1;
    end
    io_txReady = 1'b1;
    if (d < 0) begin
      checks++; failures++;
      $display("FAIL bp_timeout: no io_done");
    end else begin
      @(posedge clock); #1;
      checkInt("bp_done_cycle", d, 12 + CS);
    end
    checkInt("bp_queue_empty", expQ.size(), 0);
  endtask

  task automatic test_wrap();
    int d;
    d = -1;
    startDump(32'hFFFF_FFFE, 2);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1 || k == 7) begin
        logic [31:0] want;
        want = (k == 1) ? 32'hFFFF_FFFC : 32'h0000_0000;
        checks++;
        if (io_rdAddress !== want) begin
          failures++;
          $display("FAIL wrap_addr c%0d: got %08h required %08h", k, io_rdAddress, want);
        end else $display("wrap_addr c%0d ok %08h", k, io_rdAddress);
      end
      if (io_done) begin
        d = k;
        break;
      end
      @(posedge clock); #1;
    end
    if (d < 0) begin
      checks++; failures++;
      $display("FAIL wrap_timeout: no io_done");
    end else begin
      @(posedge clock); #1;
      checkInt("wrap_done_cycle", d, 13 + CS);
    end
    checkInt("wrap_queue_empty", expQ.size(), 0);
  endtask

  task automatic test_zero_and_ignored();
    int d;
    startDump(32'h500, 0);
    @(negedge clock);
    checks++;
    if (io_done !== 1'b1 || io_txValid !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b valid=%b required 1/0", io_done, io_txValid);
    end else $display("zero_done ok");
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b0 || io_txValid !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle: busy=%b valid=%b required 0/0", io_busy, io_txValid);
    end else $display("zero_idle ok");
    @(posedge clock); #1;

    d = -1;
    startDump(32'h100, 1);
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        io_start = 1'b1;
        io_baseAddress = 32'h300;
        io_wordCount = COUNT_W'(5);
      end else if (k == 7 + CS) begin
        io_start = 1'b1;
      end else begin
        io_start = 1'b0;
      end
      @(negedge clock);
      if (io_done) begin
        d = k;
        break;
      end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    io_start = 1'b0;
    if (d < 0) begin
      checks++; failures++;
      $display("FAIL ignored_timeout: no io_done");
    end else checkInt("ignored_done_cycle", d, 7 + CS);
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b0 || io_txValid !== 1'b0) begin
      failures++;
      $display("FAIL done_start_ignored: busy=%b valid=%b required 0/0", io_busy, io_txValid);
    end else $display("done_start_ignored ok");
    @(posedge clock); #1;
    checkInt("ignored_queue_empty", expQ.size(), 0);
  endtask

  task automatic test_reset_mid_dump();
    int d, f, doneBefore;
    startDump(32'h600, 5);
    for (int k = 1; k < 16; k++) begin
      @(negedge clock);
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (io_txValid !== 1'b0 || io_busy !== 1'b0 || io_done !== 1'b0 ||
        io_rdAddress !== 32'h0 || io_txData !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: valid=%b busy=%b done=%b addr=%08h data=%02h required all 0",
               io_txValid, io_busy, io_done, io_rdAddress, io_txData);
    end else $display("async_reset ok");
    expQ.delete();
    doneBefore = doneCount;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++;
    if (io_busy !== 1'b0 || io_txValid !== 1'b0) begin
      failures++;
      $display("FAIL no_resume: busy=%b valid=%b required 0/0", io_busy, io_txValid);
    end else $display("no_resume ok");
    checkInt("no_done_after_reset", doneCount, doneBefore);
    @(posedge clock); #1;
    startDump(32'h100, 1);
    runUntilDone(50, d, f);
    if (d >= 0) checkInt("post_reset_done_cycle", d, 7 + CS);
    checkInt("post_reset_queue_empty", expQ.size(), 0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
